// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO drained back-to-back onto TX.
// Each bit is held BAUD_DIV clocks; frames follow one another with no idle gap.
module uart_tx_buf #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_TX} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            full_reg, empty_reg;
  logic [8:0]      shift_reg;
  logic [11:0]     baud_cnt_reg;
  logic [3:0]      bit_cnt_reg;
  logic            tx_reg, tx_done_reg, busy_reg;

  logic            push, pop, load, bit_end, frame_end;

  always_comb begin
    push       = trmt && !full_reg;
    bit_end    = (state_reg == S_TX) && (baud_cnt_reg == 12'd0);
    frame_end  = bit_end && (bit_cnt_reg == 4'd9);
    // A new frame starts from IDLE or directly at the end of the previous stop bit.
    load       = !empty_reg && ((state_reg == S_IDLE) || frame_end);
    pop        = load;
    state_next = state_reg;
    if (load)
      state_next = S_TX;
    else if (frame_end)
      state_next = S_IDLE;
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (!push && pop)
      count_next = count_reg - CW'(1);
  end

  // Storage has no reset; a stale entry is unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      shift_reg    <= '1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b1;
      tx_done_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(FIFO_DEPTH));
      empty_reg <= (count_next == '0);

      if (load) begin
        shift_reg    <= {mem[rd_ptr_reg], 1'b0};
        baud_cnt_reg <= 12'(BAUD_DIV - 1);
        bit_cnt_reg  <= '0;
        tx_reg       <= 1'b0;
        busy_reg     <= 1'b1;
        tx_done_reg  <= 1'b0;
      end else if (frame_end) begin
        baud_cnt_reg <= 12'(BAUD_DIV - 1);
        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        tx_reg       <= 1'b1;
        busy_reg     <= 1'b0;
        tx_done_reg  <= 1'b1;
      end else if (bit_end) begin
        shift_reg    <= {1'b1, shift_reg[8:1]};
        tx_reg       <= shift_reg[1];
        baud_cnt_reg <= 12'(BAUD_DIV - 1);
        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
      end else if (state_reg == S_TX) begin
        baud_cnt_reg <= baud_cnt_reg - 12'd1;
      end
    end
  end

  assign TX      = tx_reg;
  assign tx_done = tx_done_reg;
  assign busy    = busy_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed and random pushes compared every cycle against a
// queue-based model of the serial line and FIFO flags.
module tb_uart_tx_buf;

  localparam int B     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, tx_done, busy, full, empty;

  int checks = 0;
  int failures = 0;

  uart_tx_buf #(.BAUD_DIV(B), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done), .busy(busy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of accepted bytes and position t within the current frame.
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  logic       active = 1'b0;
  int         t = 0;
  logic       exp_done = 1'b0;
  logic       model_ok = 1'b0;
  logic       push_ok, do_load;
  int         frames = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  always @(posedge clk) begin
    model_ok = 1'b1;
    if (rst) begin
      mq.delete();
      active = 1'b0;
      t = 0;
      exp_done = 1'b0;
    end else begin
      push_ok = trmt && (mq.size() < DEPTH);
      do_load = 1'b0;
      if (active) begin
        t++;
        if (t == 10 * B) begin
          frames++;
          $display("frame %0d sent byte %02h", frames, cur);
          if (mq.size() > 0) do_load = 1'b1;
          else begin
            active = 1'b0;
            exp_done = 1'b1;
          end
        end
      end else if (mq.size() > 0) begin
        do_load = 1'b1;
      end
      if (do_load) begin
        cur = mq.pop_front();
        active = 1'b1;
        t = 0;
        exp_done = 1'b0;
      end
      if (push_ok) mq.push_back(tx_data);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("tx", TX, active ? frame_bit(cur, t / B) : 1'b1);
      check("busy", busy, active);
      check("tx_done", tx_done, exp_done);
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
    end
  end

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    trmt = 1'b1;
    tx_data = d;
  endtask

  task automatic idle();
    @(negedge clk);
    trmt = 1'b0;
    tx_data = $urandom_range(0, 255);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || !empty) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 20000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Drive trmt for exactly the edge on which the current frame's stop bit ends.
  task automatic push_at_pop(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!(active && t == 10 * B - 1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pop_edge_timeout", n < 5000, 1'b1);
    trmt = 1'b1;
    tx_data = d;
    @(negedge clk);
    trmt = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single byte with explicit push-to-tx_done latency.
    push(8'hA5);
    idle();
    for (k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (tx_done) break;
    end
    check("latency", k, 161);
    wait_drain();

    // Back-to-back frames.
    push(8'h00); push(8'hFF); push(8'h3C); idle();
    wait_drain();

    // Overflow while a frame is in flight.
    push(8'h10); idle();
    for (int i = 1; i <= 5; i++) push(8'(i));
    idle();
    wait_drain();

    // Push on the pop edge: full (dropped), then with two queued (accepted).
    push(8'h20); idle();
    push(8'h21); push(8'h22); push(8'h23); push(8'h24); idle();
    push_at_pop(8'h99);
    wait_drain();
    push(8'h30); push(8'h31); push(8'h32); idle();
    push_at_pop(8'h33);
    wait_drain();

    // Reset in the middle of a frame.
    push(8'h5A); push(8'hC3); idle();
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      trmt = ($urandom_range(0, 99) < 4);
      tx_data = $urandom_range(0, 255);
    end
    idle();
    wait_drain();

    check("frames_seen", frames > 20, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- Buffered 8N1 UART transmitter. It is the transmit-side companion to the team's UART receiver and uses the same framing and baud divisor (50 MHz / 19200 = 2604).
- A 4-entry byte FIFO accepts writes from the core. The FIFO drains back-to-back onto the serial TX line with no idle gap between frames.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit. Legal range 2..4095; baud counter is 12 bits.
- FIFO_DEPTH, 4, byte entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- trmt  in  1  write strobe; pushes tx_data into FIFO when sampled high and full=0
- tx_data  in  8  byte to send, sampled with trmt
- TX  out  1  serial output; idles high
- tx_done  out  1  sticky; set when a frame's stop bit completes, cleared when the next frame loads
- busy  out  1  high while a frame is on the line
- full  out  1  FIFO holds FIFO_DEPTH bytes
- empty  out  1  FIFO holds 0 bytes

Behaviour:
- Reset (rst high at an edge): all state takes its reset value at that edge, including mid-frame.
  - Reset values: TX=1, tx_done=0, busy=0, full=0, empty=1.
  - FIFO pointers and count cleared; state=IDLE; baud_cnt=0; bit_cnt=0.
  - A partially sent frame is abandoned with no further bits.
- FIFO:
  - Registered write/read pointers plus a count of width log2(FIFO_DEPTH)+1.
  - Push when trmt && !full, using the registered full at that edge. trmt while full is silently dropped, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - full/empty are registered and derived from the count. Pointers wrap modulo FIFO_DEPTH.
- Frame: 10 bits, each held exactly BAUD_DIV cycles.
  - Order: start (0), data bits 0..7 LSB first, stop (1).
  - Shift register is 9 bits, loaded with {byte,1'b0}. On each bit boundary it shifts right, filling with 1. TX is driven from a flop equal to shift_reg[0].
- State machine:
  - IDLE: if !empty, go to TX. Load state: pop FIFO, load shift reg, baud_cnt=BAUD_DIV-1, bit_cnt=0, busy=1, clear tx_done. Otherwise stay in IDLE with TX=1.
  - TX: baud_cnt decrements each cycle. At baud_cnt==0: shift, baud_cnt reloads BAUD_DIV-1, bit_cnt increments.
  - Frame end is the bit boundary where bit_cnt reaches 10 (stop bit completed). tx_done is set there.
    - If !empty at that same edge: reload immediately (pop, load, clear tx_done, stay in TX). The next start bit begins at the very next cycle, with no gap and tx_done never observed high.
    - Otherwise: go to IDLE, busy=0.
- Latency: trmt sampled at edge N with FIFO empty and IDLE → empty=0 after N. Load at edge N+1, TX=0 from N+1 for BAUD_DIV cycles. Stop bit ends, and tx_done rises, at edge N+1+10*BAUD_DIV.
- A push while transmitting never disturbs the frame in flight. tx_data is captured only at push.
- No parity, single stop bit. The stop bit is held a full BAUD_DIV cycles before the next start bit.

Test Plan:
- (BAUD_DIV=16) Reset: rst high 3 cycles during an active frame → TX=1, busy=0, empty=1, tx_done=0 on the next cycle; no further TX transitions.
- Single byte: push 0xA5 at edge N → TX=0 over N+1..N+16. Then bits 1,0,1,0,0,1,0,1, 16 cycles each, then 1. tx_done=1 and busy=0 at N+161.
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous 160-cycle frames with no idle cycles; tx_done stays 0 until the end of the third frame; empty=1 after the third load.
- Overflow: with a frame in flight, push 5 bytes 0x01..0x05 → full=1 after the 4th push; 0x05 dropped; exactly 0x01..0x04 are sent in order.
- Push/pop same cycle: with 4 queued and full=1, trmt at the pop edge → byte dropped, count=3. With 2 queued, trmt at the pop edge → count stays 2.
- Receiver loopback: TX wired to the team's UART receiver (BAUD_DIV=2604), send 0x55, 0x80 → receiver rdy asserts twice with rx_data=0x55 then 0x80.
